// File: rtl/aie_chain_noc.sv
// Linear NoC of NUM_TILES stages. Each stage is a FIFO feeding a compute tile
// output register; flits addressed to a tile (or broadcast) get its operation.
module aie_chain_noc #(
   parameter int NUM_TILES  = 4,
   parameter int DATA_WIDTH = 8,
   parameter int FIFO_DEPTH = 4,
   parameter int ID_W       = $clog2(NUM_TILES) + 1
) (
   input  logic                  clk,
   input  logic                  rst_n,
   input  logic                  in_valid,
   output logic                  in_ready,
   input  logic [ID_W-1:0]       in_dest,
   input  logic [DATA_WIDTH-1:0] in_data,
   output logic                  out_valid,
   input  logic                  out_ready,
   output logic [ID_W-1:0]       out_dest,
   output logic [DATA_WIDTH-1:0] out_data,
   input  logic                  cfg_we,
   input  logic [ID_W-1:0]       cfg_tile,
   input  logic [1:0]            cfg_mode,
   input  logic [DATA_WIDTH-1:0] cfg_coeff,
   output logic [15:0]           flit_count
);

   localparam int PTR_W = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
   localparam int CNT_W = PTR_W + 1;

   typedef enum logic [1:0] {
      MODE_PASS = 2'd0,
      MODE_ADD  = 2'd1,
      MODE_MUL  = 2'd2,
      MODE_ACC  = 2'd3
   } mode_e;

   // Inter-stage wiring: up_* feeds stage i's FIFO, reg_* is stage i's output register.
   logic [NUM_TILES-1:0]  up_valid;
   logic [ID_W-1:0]       up_dest   [NUM_TILES];
   logic [DATA_WIDTH-1:0] up_data   [NUM_TILES];
   logic [NUM_TILES-1:0]  fifo_full;
   logic [NUM_TILES-1:0]  reg_valid;
   logic [ID_W-1:0]       reg_dest  [NUM_TILES];
   logic [DATA_WIDTH-1:0] reg_data  [NUM_TILES];
   logic [NUM_TILES-1:0]  down_ready;

   for (genvar i = 0; i < NUM_TILES; i++) begin : g_stage
      logic [ID_W-1:0]       mem_dest [FIFO_DEPTH];
      logic [DATA_WIDTH-1:0] mem_data [FIFO_DEPTH];
      logic [PTR_W-1:0]      wr_ptr;
      logic [PTR_W-1:0]      rd_ptr;
      logic [CNT_W-1:0]      count;
      logic                  push;
      logic                  pop;
      logic                  empty;
      mode_e                 mode;
      logic [DATA_WIDTH-1:0] coeff;
      logic [DATA_WIDTH-1:0] acc;
      logic                  cfg_hit;
      logic                  hit;
      logic [ID_W-1:0]       head_dest;
      logic [DATA_WIDTH-1:0] head_data;
      logic [DATA_WIDTH-1:0] acc_sum;
      logic [DATA_WIDTH-1:0] op_data;
      logic                  r_valid;
      logic [ID_W-1:0]       r_dest;
      logic [DATA_WIDTH-1:0] r_data;

      if (i == 0) begin : g_src_port
         assign up_valid[i] = in_valid;
         assign up_dest[i]  = in_dest;
         assign up_data[i]  = in_data;
      end else begin : g_src_prev
         assign up_valid[i] = reg_valid[i-1];
         assign up_dest[i]  = reg_dest[i-1];
         assign up_data[i]  = reg_data[i-1];
      end

      if (i == NUM_TILES - 1) begin : g_sink_port
         assign down_ready[i] = out_ready;
      end else begin : g_sink_next
         assign down_ready[i] = !fifo_full[i+1];
      end

      assign fifo_full[i] = (count == CNT_W'(FIFO_DEPTH));
      assign empty        = (count == '0);
      assign push         = up_valid[i] && !fifo_full[i];
      assign pop          = !empty && (!r_valid || down_ready[i]);
      assign cfg_hit      = cfg_we && (cfg_tile == ID_W'(i));

      // NOTE: storage has no reset; the pointers and count define what is valid.
      always_ff @(posedge clk) begin
         if (push) begin
            mem_dest[wr_ptr] <= up_dest[i];
            mem_data[wr_ptr] <= up_data[i];
         end
      end

      always_ff @(posedge clk or negedge rst_n) begin
         if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
         end else begin
            if (push) wr_ptr <= wr_ptr + PTR_W'(1);
            if (pop)  rd_ptr <= rd_ptr + PTR_W'(1);
            unique case ({push, pop})
               2'b10:   count <= count + CNT_W'(1);
               2'b01:   count <= count - CNT_W'(1);
               default: count <= count;
            endcase
         end
      end

      // NOTE: every output gets a default first so no latch is inferred.
      always_comb begin
         head_dest = mem_dest[rd_ptr];
         head_data = mem_data[rd_ptr];
         hit       = (head_dest == ID_W'(i)) || (&head_dest);
         acc_sum   = acc + head_data;
         op_data   = head_data;
         if (hit) begin
            unique case (mode)
               MODE_ADD: op_data = head_data + coeff;
               MODE_MUL: op_data = head_data * coeff;
               MODE_ACC: op_data = acc_sum;
               default:  op_data = head_data;
            endcase
         end
      end

      // A config write on the same edge as a flit load wins over the accumulator update.
      always_ff @(posedge clk or negedge rst_n) begin
         if (!rst_n) begin
            mode  <= MODE_PASS;
            coeff <= '0;
            acc   <= '0;
         end else if (cfg_hit) begin
            mode  <= mode_e'(cfg_mode);
            coeff <= cfg_coeff;
            acc   <= '0;
         end else if (pop && hit && mode == MODE_ACC) begin
            acc <= acc_sum;
         end
      end

      always_ff @(posedge clk or negedge rst_n) begin
         if (!rst_n) begin
            r_valid <= 1'b0;
            r_dest  <= '0;
            r_data  <= '0;
         end else if (pop) begin
            r_valid <= 1'b1;
            r_dest  <= head_dest;
            r_data  <= op_data;
         end else if (down_ready[i]) begin
            r_valid <= 1'b0;
         end
      end

      assign reg_valid[i] = r_valid;
      assign reg_dest[i]  = r_dest;
      assign reg_data[i]  = r_data;
   end

   assign in_ready  = !fifo_full[0];
   assign out_valid = reg_valid[NUM_TILES-1];
   assign out_dest  = reg_dest[NUM_TILES-1];
   assign out_data  = reg_data[NUM_TILES-1];

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         flit_count <= '0;
      end else if (out_valid && out_ready) begin
         flit_count <= flit_count + 16'd1;
      end
   end

endmodule

// File: tb/tb_aie_chain_noc.sv
// Directed bench for aie_chain_noc: latency, addressing, broadcast, accumulate,
// config corner cases, backpressure capacity/ordering and mid-traffic reset.
module tb_aie_chain_noc;

   localparam int ID_W = 3;

   logic            clk;
   logic            rst_n;
   logic            in_valid;
   logic            in_ready;
   logic [ID_W-1:0] in_dest;
   logic [7:0]      in_data;
   logic            out_valid;
   logic            out_ready;
   logic [ID_W-1:0] out_dest;
   logic [7:0]      out_data;
   logic            cfg_we;
   logic [ID_W-1:0] cfg_tile;
   logic [1:0]      cfg_mode;
   logic [7:0]      cfg_coeff;
   logic [15:0]     flit_count;

   int total = 0;
   int bad   = 0;
   int exp_count = 0;

   aie_chain_noc #(
      .NUM_TILES (4),
      .DATA_WIDTH(8),
      .FIFO_DEPTH(4),
      .ID_W      (ID_W)
   ) dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .in_dest   (in_dest),
      .in_data   (in_data),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .out_dest  (out_dest),
      .out_data  (out_data),
      .cfg_we    (cfg_we),
      .cfg_tile  (cfg_tile),
      .cfg_mode  (cfg_mode),
      .cfg_coeff (cfg_coeff),
      .flit_count(flit_count)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   initial begin
      #300000;
      $display("FAIL watchdog: simulation did not finish, observed=timeout required=finish");
      $fatal(1, "watchdog");
   end

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      total++;
      assert (obs === exp) else begin
         bad++;
         $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic cfg(input logic [ID_W-1:0] tile, input logic [1:0] mode, input logic [7:0] coeff);
      cfg_we    = 1'b1;
      cfg_tile  = tile;
      cfg_mode  = mode;
      cfg_coeff = coeff;
      tick();
      cfg_we = 1'b0;
   endtask

   task automatic push(input logic [ID_W-1:0] d, input logic [7:0] v);
      int cyc = 0;
      in_valid = 1'b1;
      in_dest  = d;
      in_data  = v;
      while (!in_ready && cyc < 100) begin
         tick();
         cyc++;
      end
      if (!in_ready) check("push timeout", {31'd0, in_ready}, 32'd1);
      tick();
      in_valid = 1'b0;
   endtask

   task automatic expect_out(input string tag, input logic [ID_W-1:0] d, input logic [7:0] v);
      int cyc = 0;
      out_ready = 1'b1;
      while (!out_valid && cyc < 100) begin
         tick();
         cyc++;
      end
      check({tag, " valid"}, {31'd0, out_valid}, 32'd1);
      check({tag, " dest"}, {29'd0, out_dest}, {29'd0, d});
      check({tag, " data"}, {24'd0, out_data}, {24'd0, v});
      if (out_valid) begin
         tick();
         exp_count++;
      end
   endtask

   initial begin
      int cyc;
      int n;
      int idx;

      rst_n     = 1'b0;
      in_valid  = 1'b0;
      in_dest   = '0;
      in_data   = '0;
      out_ready = 1'b0;
      cfg_we    = 1'b0;
      cfg_tile  = '0;
      cfg_mode  = '0;
      cfg_coeff = '0;
      tick();
      tick();

      check("rst out_valid", {31'd0, out_valid}, 32'd0);
      check("rst out_data", {24'd0, out_data}, 32'd0);
      check("rst out_dest", {29'd0, out_dest}, 32'd0);
      check("rst flit_count", {16'd0, flit_count}, 32'd0);
      #3 rst_n = 1'b1;
      tick();
      check("rst in_ready", {31'd0, in_ready}, 32'd1);

      // Latency through an empty pipeline is 2*NUM_TILES-1 edges after the accept edge.
      out_ready = 1'b1;
      push(3'd0, 8'h12);
      cyc = 0;
      while (!out_valid && cyc < 50) begin
         tick();
         cyc++;
      end
      check("latency", cyc, 32'd7);
      check("pass data", {24'd0, out_data}, 32'h12);
      check("pass dest", {29'd0, out_dest}, 32'd0);
      tick();
      exp_count++;
      check("pass count", {16'd0, flit_count}, exp_count);
      check("pass drained", {31'd0, out_valid}, 32'd0);

      cfg(3'd2, 2'd1, 8'hF0);
      push(3'd2, 8'h20);
      push(3'd1, 8'h20);
      expect_out("add wrap", 3'd2, 8'h10);
      expect_out("add other", 3'd1, 8'h20);

      for (int t = 0; t < 4; t++) cfg(ID_W'(t), 2'd1, 8'd1);
      push(3'b111, 8'd5);
      expect_out("bcast add", 3'b111, 8'd9);
      cfg(3'd1, 2'd2, 8'd3);
      push(3'b111, 8'd5);
      expect_out("bcast mul", 3'b111, 8'd20);

      cfg(3'd1, 2'd3, 8'd0);
      push(3'd1, 8'd3);
      push(3'd1, 8'd4);
      push(3'd1, 8'd5);
      expect_out("acc 1", 3'd1, 8'd3);
      expect_out("acc 2", 3'd1, 8'd7);
      expect_out("acc 3", 3'd1, 8'd12);
      cfg(3'd1, 2'd3, 8'd0);
      push(3'd1, 8'd1);
      expect_out("acc clear", 3'd1, 8'd1);

      // Out-of-range and broadcast tile IDs must not touch any tile configuration.
      cfg(3'd4, 2'd1, 8'h80);
      cfg(3'b111, 2'd2, 8'd0);
      push(3'd1, 8'd2);
      expect_out("cfg ignored", 3'd1, 8'd3);

      // Flit loads tile0's register on the same edge as a config write to tile0.
      push(3'd0, 8'h40);
      cfg(3'd0, 2'd0, 8'd0);
      expect_out("cfg collide", 3'd0, 8'h41);
      check("count mid", {16'd0, flit_count}, exp_count);

      out_ready = 1'b0;
      n = 0;
      for (int c = 0; c < 60; c++) begin
         if (in_ready) begin
            in_valid = 1'b1;
            in_dest  = 3'd0;
            in_data  = n[7:0];
         end else begin
            in_valid = 1'b0;
         end
         tick();
         if (in_valid) n++;
      end
      in_valid = 1'b0;
      check("capacity", n, 32'd20);
      check("full in_ready", {31'd0, in_ready}, 32'd0);

      idx = 0;
      cyc = 0;
      while (idx < 20 && cyc < 1000) begin
         out_ready = 1'($urandom_range(0, 1));
         if (out_valid && out_ready) begin
            check("drain order", {24'd0, out_data}, idx);
            idx++;
            exp_count++;
         end
         tick();
         cyc++;
      end
      check("drain total", idx, 32'd20);
      out_ready = 1'b1;
      for (int c = 0; c < 12; c++) tick();
      check("no extra flit", {31'd0, out_valid}, 32'd0);
      check("count drain", {16'd0, flit_count}, exp_count);

      out_ready = 1'b0;
      for (int k = 0; k < 10; k++) push(3'd3, 8'(8'h80 + k));
      for (int c = 0; c < 10; c++) tick();
      check("inflight valid", {31'd0, out_valid}, 32'd1);
      #3 rst_n = 1'b0;
      #1;
      check("async out_valid", {31'd0, out_valid}, 32'd0);
      check("async flit_count", {16'd0, flit_count}, 32'd0);
      check("async in_ready", {31'd0, in_ready}, 32'd1);
      tick();
      rst_n = 1'b1;
      exp_count = 0;
      tick();
      out_ready = 1'b1;
      push(3'd2, 8'h55);
      expect_out("post reset", 3'd2, 8'h55);
      check("post reset count", {16'd0, flit_count}, exp_count);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
